// File: rtl/conv3x3_window.sv
// rtl/conv3x3_window.sv - 3x3 sliding-window convolution with normalise and saturate.
`timescale 1ns/1ps

module conv3x3_window #(
  parameter int DATA_W   = 8,
  parameter int KERNEL_W = 3,
  parameter int IMG_W    = 512,
  parameter int COEF_W   = 8,
  parameter int SHIFT    = 4
) (
  input  logic                             clk_i,
  input  logic                             srst_i,
  input  logic [KERNEL_W-1:0][DATA_W-1:0]  col_i,
  input  logic                             col_valid_i,
  input  logic                             coef_wr_i,
  input  logic [3:0]                       coef_addr_i,
  input  logic signed [COEF_W-1:0]         coef_data_i,
  output logic [DATA_W-1:0]                pix_o,
  output logic                             pix_valid_o,
  output logic                             eol_o
);

  localparam int CNT_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int PROD_W = DATA_W + 1 + COEF_W;
  localparam int SUM_W  = DATA_W + COEF_W + 5;

  // Identity centre tap; clamps to the largest positive code when 2**SHIFT does not fit.
  localparam int ID_INT = (SHIFT > COEF_W - 2) ? ((2 ** (COEF_W - 1)) - 1) : (2 ** SHIFT);
  localparam logic signed [COEF_W-1:0] COEF_ID = COEF_W'(ID_INT);

  localparam int RND_INT = (SHIFT > 0) ? (1 << ((SHIFT > 0) ? (SHIFT - 1) : 0)) : 0;
  localparam logic signed [SUM_W:0] RND     = (SUM_W + 1)'(RND_INT);
  localparam logic signed [SUM_W:0] PIX_MAX = (SUM_W + 1)'((2 ** DATA_W) - 1);
  localparam logic [CNT_W-1:0]      LAST_COL = CNT_W'(IMG_W - 1);

  logic [CNT_W-1:0]         r_col_cnt;
  logic [DATA_W-1:0]        r_win [3][3];
  logic signed [COEF_W-1:0] r_coef [9];
  logic signed [COEF_W-1:0] r_kcoef [9];
  logic                     r_win_vld;
  logic                     r_win_eol;

  logic signed [PROD_W-1:0] r_prod [9];
  logic                     r_s1_vld;
  logic                     r_s1_eol;

  logic signed [SUM_W-1:0]  r_sum;
  logic                     r_s2_vld;
  logic                     r_s2_eol;

  logic                     w_accept;
  logic                     w_complete;
  logic                     w_last;
  logic signed [PROD_W-1:0] w_prod [9];
  logic signed [SUM_W-1:0]  w_sum;
  logic signed [SUM_W:0]    w_round;
  logic signed [SUM_W:0]    w_shift;
  logic [DATA_W-1:0]        w_sat;

  assign w_accept   = col_valid_i & ~srst_i;
  assign w_complete = (r_col_cnt >= CNT_W'(2));
  assign w_last     = (r_col_cnt == LAST_COL);

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_col_cnt <= '0;
      r_win_vld <= 1'b0;
      r_win_eol <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else begin
      r_win_vld <= w_accept & w_complete;
      r_win_eol <= w_accept & w_complete & w_last;
      if (w_accept) begin
        r_col_cnt <= w_last ? '0 : r_col_cnt + CNT_W'(1);
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
          r_win[r][2] <= col_i[r];
        end
      end
    end
  end

  // Kernel snapshot taken on the accepting edge, so a write on that same edge is not yet visible.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      for (int i = 0; i < 9; i++) begin
        r_kcoef[i] <= r_coef[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      for (int i = 0; i < 9; i++) begin
        r_coef[i] <= (i == 4) ? COEF_ID : '0;
      end
    end else if (coef_wr_i) begin
      for (int i = 0; i < 9; i++) begin
        if (coef_addr_i == 4'(i)) begin
          r_coef[i] <= coef_data_i;
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        w_prod[r*3+c] = PROD_W'($signed({1'b0, r_win[r][c]})) * PROD_W'(r_kcoef[r*3+c]);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_s1_vld <= 1'b0;
      r_s1_eol <= 1'b0;
    end else begin
      r_s1_vld <= r_win_vld;
      r_s1_eol <= r_win_eol;
    end
  end

  always_ff @(posedge clk_i) begin
    if (r_win_vld) begin
      for (int i = 0; i < 9; i++) begin
        r_prod[i] <= w_prod[i];
      end
    end
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 9; i++) begin
      w_sum = w_sum + SUM_W'(r_prod[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_s2_vld <= 1'b0;
      r_s2_eol <= 1'b0;
    end else begin
      r_s2_vld <= r_s1_vld;
      r_s2_eol <= r_s1_eol;
    end
  end

  always_ff @(posedge clk_i) begin
    if (r_s1_vld) begin
      r_sum <= w_sum;
    end
  end

  assign w_round = (SUM_W + 1)'(r_sum) + RND;
  assign w_shift = w_round >>> SHIFT;

  always_comb begin
    if (w_shift[SUM_W]) begin
      w_sat = '0;
    end else if (w_shift > PIX_MAX) begin
      w_sat = '1;
    end else begin
      w_sat = w_shift[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      pix_o       <= '0;
      pix_valid_o <= 1'b0;
      eol_o       <= 1'b0;
    end else begin
      pix_valid_o <= r_s2_vld;
      eol_o       <= r_s2_eol;
      if (r_s2_vld) begin
        pix_o <= w_sat;
      end
    end
  end

endmodule
